dll_sar_ctrl: RTL and testbench
===============================

DLL_SAR_CTRL -- requirements
Module: dll_sar_ctrl

Interface
REQ-001 Parameter CODE_W, default 10, SHALL set the DCDL control code width.
REQ-002 Parameter SETTLE, default 8, SHALL set the wait in cycles after any code change before a phase sample is accepted.
REQ-003 Parameter FILT, default 4, SHALL set the number of phase samples per tracking decision.
REQ-004 CLK_exit  in  1  SHALL be the single clock (reference clock); rising edge.
REQ-005 rst_n  in  1  SHALL be the reset: asynchronous assert, active-low.
REQ-006 start  in  1  SHALL be a one-cycle pulse that (re)launches acquisition from any state.
REQ-007 pd_valid  in  1  SHALL be a one-cycle strobe marking pd_late as a valid phase-detector sample.
REQ-008 pd_late  in  1  SHALL be 1 when CLK_out lags the reference (delay too long) and 0 otherwise.
REQ-009 Q  out  CODE_W  SHALL be the registered delay code driven to the DCDL.
REQ-010 busy  out  1  SHALL be high during SAR acquisition.
REQ-011 lock  out  1  SHALL be high while tracking after a completed acquisition.
REQ-012 sat_err  out  1  SHALL be a sticky flag for a tracking step clamped at code 0 or code 2^CODE_W-1.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, SAR_SETTLE, SAR_SAMPLE, TRK_SETTLE and TRK_SAMPLE.
REQ-014 In IDLE, a start pulse SHALL load Q=2^(CODE_W-1), set the bit index to CODE_W-1, assert busy and enter SAR_SETTLE.
REQ-015 In any *_SETTLE state, the block SHALL count SETTLE cycles, then move to the matching *_SAMPLE state; pd_valid SHALL be ignored while settling.
REQ-016 In SAR_SAMPLE, on pd_valid, pd_late=1 SHALL clear the bit under test and pd_late=0 SHALL keep it.
REQ-017 In SAR_SAMPLE, when the bit index is above 0, the block SHALL set the next lower bit, decrement the index and return to SAR_SETTLE.
REQ-018 In SAR_SAMPLE, when the bit index is 0, the block SHALL deassert busy, assert lock, clear the filter and enter TRK_SETTLE.
REQ-019 Q SHALL update on the clock edge that consumes pd_valid; the new code SHALL be visible one cycle after the strobe.
REQ-020 In TRK_SAMPLE, each pd_valid SHALL add +1 (late) or -1 (early) to a signed filter accumulator and increment a sample count.
REQ-021 After FILT samples, an accumulator equal to +FILT SHALL decrement Q and an accumulator equal to -FILT SHALL increment Q; any other value SHALL hold Q.
REQ-022 After each tracking decision, the accumulator and count SHALL clear; the next state SHALL be TRK_SETTLE if Q changed and TRK_SAMPLE otherwise.
REQ-023 A tracking step that would go below 0 or above max SHALL leave Q clamped and SHALL set sat_err.
REQ-024 sat_err SHALL clear only on reset or start.
REQ-025 lock SHALL remain high through clamped steps.
REQ-026 start in any non-IDLE state SHALL abort the current operation, clear lock and sat_err, and restart per REQ-014 on the same edge.
REQ-027 start and pd_valid in the same cycle SHALL give start priority; the sample SHALL be discarded.
REQ-028 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-029 While rst_n=0, the block SHALL force state=IDLE, Q=2^(CODE_W-1), busy=0, lock=0, sat_err=0, and clear all counters and the accumulator.
REQ-030 Reset asserted mid-acquisition or mid-tracking SHALL take effect immediately, with no completion of the pending step.
REQ-031 After rst_n rises, the block SHALL stay in IDLE until start.

Structure
REQ-032 A shared package SHALL hold the FSM state enumeration and the default values of CODE_W, SETTLE and FILT.
REQ-033 The settle counter SHALL be one sub-module, dll_settle_timer (load/count/done), instantiated once and shared by SAR and tracking.
REQ-034 The remaining logic (FSM, SAR register, filter) SHALL be in dll_sar_ctrl, at roughly 150-250 lines of RTL.

Verification
REQ-035 Scenario: bench model pd_late=(Q>300), pd_valid on every sample-state cycle, start -> busy falls after 10 SAR steps; Q=300, lock=1.
REQ-036 Scenario: target 0 -> Q=0 after SAR; sustained late samples set sat_err=1 after FILT=4 samples with Q held at 0.
REQ-037 Scenario: lock at Q=300, target moved to 302 -> Q=301 and then 302, each after 4 early samples plus SETTLE; alternating samples hold Q=302.
REQ-038 Scenario: pd_valid pulses during every settle window -> ignored; SAR result is unchanged versus REQ-035 and each step lasts at least SETTLE+1 cycles.
REQ-039 Scenario: start re-pulsed at SAR bit 5 -> Q=512 next cycle and acquisition restarts; start coincident with pd_valid -> the sample is dropped.
REQ-040 Scenario: rst_n pulled low mid-tracking for 1 cycle asynchronously -> Q=512, lock=0 and sat_err=0 immediately; IDLE is held until start.

Source files
------------

// File: rtl/dll_sar_ctrl_pkg.sv
// Shared definitions for the DLL SAR delay-code controller.
package dll_sar_ctrl_pkg;

    localparam int CODE_W_DEF = 10;
    localparam int SETTLE_DEF = 8;
    localparam int FILT_DEF   = 4;

    typedef enum logic [2:0] {
        IDLE,
        SAR_SETTLE,
        SAR_SAMPLE,
        TRK_SETTLE,
        TRK_SAMPLE
    } state_t;

endpackage

// File: rtl/dll_settle_timer.sv
// Settle timer shared by SAR and tracking: load arms a SETTLE-cycle window,
// count advances it, done is high once the window has elapsed.
module dll_settle_timer
    import dll_sar_ctrl_pkg::*;
#(
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic count,
    output logic done
);

    localparam int TW = (SETTLE > 2) ? $clog2(SETTLE) : 1;

    logic [TW-1:0] cnt;

    // Load SETTLE-1 so done rises in the SETTLE-th settling cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= TW'(SETTLE - 1);
        end else if (count && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/dll_sar_ctrl.sv
// DLL delay-code controller: binary-search acquisition of the DCDL code,
// followed by filtered +/-1 tracking with clamp detection.
module dll_sar_ctrl
    import dll_sar_ctrl_pkg::*;
#(
    parameter int CODE_W = CODE_W_DEF,
    parameter int SETTLE = SETTLE_DEF,
    parameter int FILT   = FILT_DEF
) (
    input  logic              CLK_exit,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pd_valid,
    input  logic              pd_late,
    output logic [CODE_W-1:0] Q,
    output logic              busy,
    output logic              lock,
    output logic              sat_err
);

    localparam int IDX_W = (CODE_W > 2) ? $clog2(CODE_W) : 1;
    localparam int CNT_W = $clog2(FILT + 1);
    localparam int ACC_W = CNT_W + 1;

    localparam logic [CODE_W-1:0]       Q_MID    = {1'b1, {(CODE_W-1){1'b0}}};
    localparam logic [IDX_W-1:0]        IDX_TOP  = IDX_W'(CODE_W - 1);
    localparam logic [CNT_W-1:0]        CNT_FULL = CNT_W'(FILT);
    localparam logic signed [ACC_W-1:0] ACC_ONE  = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] ACC_POS  = ACC_W'(FILT);
    localparam logic signed [ACC_W-1:0] ACC_NEG  = -ACC_POS;

    state_t                    state_q, state_d;
    logic [CODE_W-1:0]         q_d, q_tmp;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      busy_d, lock_d, sat_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d, acc_tmp;
    logic [CNT_W-1:0]          cnt_q, cnt_d, cnt_tmp;
    logic                      tmr_load, tmr_count, tmr_done;

    dll_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk   (CLK_exit),
        .rst_n (rst_n),
        .load  (tmr_load),
        .count (tmr_count),
        .done  (tmr_done)
    );

    // State, code, filter and flag registers.
    always_ff @(posedge CLK_exit or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            Q       <= Q_MID;
            idx_q   <= '0;
            busy    <= 1'b0;
            lock    <= 1'b0;
            sat_err <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            Q       <= q_d;
            idx_q   <= idx_d;
            busy    <= busy_d;
            lock    <= lock_d;
            sat_err <= sat_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: start overrides everything, including a coincident sample.
    always_comb begin
        state_d   = state_q;
        q_d       = Q;
        idx_d     = idx_q;
        busy_d    = busy;
        lock_d    = lock;
        sat_d     = sat_err;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        tmr_load  = 1'b0;
        tmr_count = 1'b0;
        q_tmp     = Q;
        acc_tmp   = acc_q;
        cnt_tmp   = cnt_q;

        if (start) begin
            state_d  = SAR_SETTLE;
            q_d      = Q_MID;
            idx_d    = IDX_TOP;
            busy_d   = 1'b1;
            lock_d   = 1'b0;
            sat_d    = 1'b0;
            acc_d    = '0;
            cnt_d    = '0;
            tmr_load = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                end
                SAR_SETTLE: begin
                    if (tmr_done) state_d = SAR_SAMPLE;
                    else          tmr_count = 1'b1;
                end
                SAR_SAMPLE: begin
                    if (pd_valid) begin
                        if (pd_late) q_tmp[idx_q] = 1'b0;
                        if (idx_q != '0) begin
                            q_tmp[idx_q - 1'b1] = 1'b1;
                            idx_d   = idx_q - 1'b1;
                            state_d = SAR_SETTLE;
                        end else begin
                            busy_d  = 1'b0;
                            lock_d  = 1'b1;
                            acc_d   = '0;
                            cnt_d   = '0;
                            state_d = TRK_SETTLE;
                        end
                        q_d      = q_tmp;
                        tmr_load = 1'b1;
                    end
                end
                TRK_SETTLE: begin
                    if (tmr_done) state_d = TRK_SAMPLE;
                    else          tmr_count = 1'b1;
                end
                TRK_SAMPLE: begin
                    if (pd_valid) begin
                        acc_tmp = acc_q + (pd_late ? ACC_ONE : -ACC_ONE);
                        cnt_tmp = cnt_q + 1'b1;
                        if (cnt_tmp == CNT_FULL) begin
                            acc_d = '0;
                            cnt_d = '0;
                            // A clamped step leaves the code untouched, so no re-settle.
                            if (acc_tmp == ACC_POS) begin
                                if (Q == '0) begin
                                    sat_d = 1'b1;
                                end else begin
                                    q_d      = Q - 1'b1;
                                    state_d  = TRK_SETTLE;
                                    tmr_load = 1'b1;
                                end
                            end else if (acc_tmp == ACC_NEG) begin
                                if (Q == '1) begin
                                    sat_d = 1'b1;
                                end else begin
                                    q_d      = Q + 1'b1;
                                    state_d  = TRK_SETTLE;
                                    tmr_load = 1'b1;
                                end
                            end
                        end else begin
                            acc_d = acc_tmp;
                            cnt_d = cnt_tmp;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dll_sar_ctrl.sv
// Self-checking bench for dll_sar_ctrl: closed-loop phase detector stimulus,
// a transaction-level reference model compared every cycle, plus literal checks.
module tb_dll_sar_ctrl;

    localparam int CODE_W = 10;
    localparam int SETTLE = 8;
    localparam int FILT   = 4;
    localparam int QMAX   = (1 << CODE_W) - 1;
    localparam int QMID   = 1 << (CODE_W - 1);

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              start    = 1'b0;
    logic              pd_valid = 1'b0;
    logic              pd_late  = 1'b0;
    logic [CODE_W-1:0] Q;
    logic              busy, lock, sat_err;

    dll_sar_ctrl #(
        .CODE_W (CODE_W),
        .SETTLE (SETTLE),
        .FILT   (FILT)
    ) dut (
        .CLK_exit (clk),
        .rst_n    (rst_n),
        .start    (start),
        .pd_valid (pd_valid),
        .pd_late  (pd_late),
        .Q        (Q),
        .busy     (busy),
        .lock     (lock),
        .sat_err  (sat_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode 0 idle, 1 acquiring, 2 tracking.
    typedef struct {
        int mode;
        int q;
        int idx;
        int settle_left;
        int acc;
        int cnt;
        bit busy;
        bit lock;
        bit sat;
    } mdl_t;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.mode = 0; r.q = QMID; r.idx = 0; r.settle_left = 0;
        r.acc = 0; r.cnt = 0; r.busy = 0; r.lock = 0; r.sat = 0;
        return r;
    endfunction

    function automatic mdl_t mdl_next(input mdl_t s, input bit st, input bit v, input bit late);
        mdl_t n = s;
        if (st) begin
            n.mode = 1; n.q = QMID; n.idx = CODE_W - 1; n.settle_left = SETTLE;
            n.busy = 1; n.lock = 0; n.sat = 0; n.acc = 0; n.cnt = 0;
        end else if (s.mode != 0 && s.settle_left > 0) begin
            n.settle_left = s.settle_left - 1;
        end else if (s.mode == 1 && v) begin
            if (late) n.q = n.q - (1 << s.idx);
            if (s.idx > 0) begin
                n.idx = s.idx - 1;
                n.q   = n.q + (1 << n.idx);
            end else begin
                n.mode = 2; n.busy = 0; n.lock = 1; n.acc = 0; n.cnt = 0;
            end
            n.settle_left = SETTLE;
        end else if (s.mode == 2 && v) begin
            n.acc = s.acc + (late ? 1 : -1);
            n.cnt = s.cnt + 1;
            if (n.cnt == FILT) begin
                if (n.acc == FILT) begin
                    if (s.q == 0) n.sat = 1;
                    else begin n.q = s.q - 1; n.settle_left = SETTLE; end
                end else if (n.acc == -FILT) begin
                    if (s.q == QMAX) n.sat = 1;
                    else begin n.q = s.q + 1; n.settle_left = SETTLE; end
                end
                n.acc = 0;
                n.cnt = 0;
            end
        end
        return n;
    endfunction

    mdl_t m;

    // Model state advances on the same edges as the DUT, reset asynchronously.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= mdl_reset();
        else        m <= mdl_next(m, start, pd_valid, pd_late);
    end

    // Stimulus controls for the phase-detector process.
    int target    = 300;
    int pd_mode   = 0;   // 0 none, 1 only in sample windows, 2 every cycle
    bit force_late = 0;
    bit alt       = 0;
    bit alt_ph    = 0;
    bit cmp_en    = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run_start(output int cyc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 400) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic wait_q_change(input int from, output int k);
        k = 0;
        while (int'(Q) == from && k < 200) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        int cyc;
        int k;
        m = mdl_reset();
        fork
            // Phase detector: late when the code exceeds the target.
            forever begin
                @(negedge clk);
                case (pd_mode)
                    1:       pd_valid = (m.mode != 0 && m.settle_left == 0);
                    2:       pd_valid = 1'b1;
                    default: pd_valid = 1'b0;
                endcase
                if (alt) begin
                    if (pd_valid) alt_ph = ~alt_ph;
                    pd_late = alt_ph;
                end else begin
                    pd_late = force_late || (int'(Q) > target);
                end
            end
            // Per-cycle comparison against the model.
            forever begin
                @(negedge clk);
                if (cmp_en) begin
                    chk("cyc_Q",    int'(Q),       m.q);
                    chk("cyc_busy", int'(busy),    int'(m.busy));
                    chk("cyc_lock", int'(lock),    int'(m.lock));
                    chk("cyc_sat",  int'(sat_err), int'(m.sat));
                end
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_Q",    int'(Q), QMID);
        chk("rst_busy", int'(busy), 0);
        chk("rst_lock", int'(lock), 0);
        chk("rst_sat",  int'(sat_err), 0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        pd_mode = 2;
        repeat (6) @(negedge clk);
        chk("idle_Q",    int'(Q), QMID);
        chk("idle_busy", int'(busy), 0);

        // Acquisition to 300: ten steps of SETTLE+1 cycles
        pd_mode = 1;
        target  = 300;
        run_start(cyc);
        chk("sar_cycles", cyc, 90);
        chk("sar_Q",      int'(Q), 300);
        chk("sar_lock",   int'(lock), 1);

        // Tracking to 302 one code at a time
        target = 302;
        wait_q_change(300, k);
        chk("trk1_Q",   int'(Q), 301);
        chk("trk1_cyc", k, 12);
        wait_q_change(301, k);
        chk("trk2_Q",   int'(Q), 302);
        chk("trk2_cyc", k, 12);
        alt    = 1'b1;
        alt_ph = 1'b0;
        repeat (40) @(negedge clk);
        chk("alt_hold_Q",    int'(Q), 302);
        chk("alt_hold_lock", int'(lock), 1);
        alt = 1'b0;

        // Acquisition to 0, then clamp on sustained late samples
        target = 0;
        run_start(cyc);
        chk("zero_Q", int'(Q), 0);
        force_late = 1'b1;
        k = 0;
        while (sat_err !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("sat_cyc",  k, 12);
        chk("sat_Q",    int'(Q), 0);
        chk("sat_lock", int'(lock), 1);
        repeat (20) @(negedge clk);
        chk("sat_sticky", int'(sat_err), 1);
        chk("sat_hold_Q", int'(Q), 0);

        // Asynchronous reset pulse mid-tracking
        #2 rst_n = 1'b0;
        #1;
        chk("arst_Q",    int'(Q), QMID);
        chk("arst_lock", int'(lock), 0);
        chk("arst_sat",  int'(sat_err), 0);
        #10 rst_n = 1'b1;
        force_late = 1'b0;
        pd_mode = 2;
        @(negedge clk);
        repeat (20) @(negedge clk);
        chk("post_rst_Q",    int'(Q), QMID);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_lock", int'(lock), 0);

        // Samples on every cycle: settle windows ignore them
        target = 300;
        run_start(cyc);
        chk("pdall_cycles", cyc, 90);
        chk("pdall_Q",      int'(Q), 300);

        // Restart at bit 5, then start coincident with a sample
        pd_mode = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(m.idx == 5 && m.settle_left == 4) && k < 200) begin
            @(negedge clk);
            k++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_Q",    int'(Q), QMID);
        chk("restart_busy", int'(busy), 1);
        k = 0;
        while (!(m.mode == 1 && m.settle_left == 0) && k < 50) begin
            @(negedge clk);
            k++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_pd_Q", int'(Q), QMID);
        cyc = 0;
        while (busy === 1'b1 && cyc < 400) begin
            cyc++;
            @(negedge clk);
        end
        chk("restart_final_Q", int'(Q), 300);
        chk("restart_cycles",  cyc, 90);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
